// File: rtl/pixel_row_readout_pkg.sv
// Shared sizing constants and types for the pixel sensor readout path.
package PixelSensorConfig;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PIXEL_ARRAY_WIDTH  = 2;
  localparam int PIXEL_ARRAY_HEIGHT = 2;
  localparam int PIXEL_BITS         = 8;
  localparam int ROW_IDX_BITS       = idx_bits(PIXEL_ARRAY_HEIGHT);
  localparam int COL_IDX_BITS       = idx_bits(PIXEL_ARRAY_WIDTH);

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/row_pingpong_buffer.sv
// Two-entry row store with tags; a write lands one edge after wr_en, a read entry frees on rd_release.
// Backpressure: wr_accept is low only when both entries are full and none is released on that edge.
module row_pingpong_buffer
  import PixelSensorConfig::*;
#(
  parameter int ROW_BITS = PIXEL_ARRAY_WIDTH * PIXEL_BITS,
  parameter int TAG_BITS = ROW_IDX_BITS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_data,
  input  logic [TAG_BITS-1:0] wr_row,
  output logic                wr_accept,
  input  logic                rd_release,
  output logic [ROW_BITS-1:0] rd_data,
  output logic [TAG_BITS-1:0] rd_row,
  output logic                rd_full,
  output logic [ROW_BITS-1:0] nxt_data,
  output logic [TAG_BITS-1:0] nxt_row,
  output logic                nxt_full,
  output logic                any_full
);

  logic [ROW_BITS-1:0] row_mem [2];
  logic [TAG_BITS-1:0] row_tag [2];
  logic [1:0]          full;
  logic                wr_ptr;
  logic                rd_ptr;

  // An entry released on this edge may be refilled on the same edge.
  assign wr_accept = wr_en && (!full[wr_ptr] || (rd_release && (rd_ptr == wr_ptr)));

  assign rd_data  = row_mem[rd_ptr];
  assign rd_row   = row_tag[rd_ptr];
  assign rd_full  = full[rd_ptr];
  assign nxt_data = row_mem[~rd_ptr];
  assign nxt_row  = row_tag[~rd_ptr];
  assign nxt_full = full[~rd_ptr];
  assign any_full = |full;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (rd_release) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if (wr_accept) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      row_mem[wr_ptr] <= wr_data;
      row_tag[wr_ptr] <= wr_row;
    end
  end

endmodule

// File: rtl/pixel_row_readout.sv
// Captures sensor rows into a ping-pong buffer and streams them one pixel per beat; first beat one cycle after capture.
// OUT_READY low holds the beat stable; with both buffers full a new row is dropped and OVERFLOW sticks.
module pixel_row_readout
  import PixelSensorConfig::*;
#(
  parameter  int WIDTH  = PIXEL_ARRAY_WIDTH,
  parameter  int HEIGHT = PIXEL_ARRAY_HEIGHT,
  parameter  int BITS   = PIXEL_BITS,
  localparam int RW     = idx_bits(HEIGHT),
  localparam int CW     = idx_bits(WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  NEW_ROW,
  input  logic [WIDTH*BITS-1:0] PIXEL_DATA,
  input  logic                  FRAME_FINISHED,
  output logic [BITS-1:0]       OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [RW-1:0]         OUT_ROW,
  output logic [CW-1:0]         OUT_COL,
  output logic                  OUT_FIRST,
  output logic                  OUT_LAST,
  output logic                  OVERFLOW,
  output logic                  BUSY
);

  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

  stream_state_t         state;
  logic [RW-1:0]         cap_row;
  logic                  wr_accept, rd_full, nxt_full, any_full;
  logic                  rd_release, xfer, load;
  logic [WIDTH*BITS-1:0] rd_data, nxt_data, ld_data;
  logic [RW-1:0]         rd_row, nxt_row, ld_row;
  logic [CW-1:0]         ld_col;

  row_pingpong_buffer #(.ROW_BITS(WIDTH*BITS), .TAG_BITS(RW)) u_buf (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_en      (NEW_ROW),
    .wr_data    (PIXEL_DATA),
    .wr_row     (cap_row),
    .wr_accept  (wr_accept),
    .rd_release (rd_release),
    .rd_data    (rd_data),
    .rd_row     (rd_row),
    .rd_full    (rd_full),
    .nxt_data   (nxt_data),
    .nxt_row    (nxt_row),
    .nxt_full   (nxt_full),
    .any_full   (any_full)
  );

  assign xfer       = (state == S_STREAM) && OUT_VALID && OUT_READY;
  assign rd_release = xfer && (OUT_COL == LAST_COL);
  assign BUSY       = any_full || OUT_VALID;

  // Pick the next beat: start of a new row, next column, or back-to-back row.
  always_comb begin
    load    = 1'b0;
    ld_data = rd_data;
    ld_row  = rd_row;
    ld_col  = '0;
    if (state == S_IDLE) begin
      load = rd_full;
    end else if (xfer) begin
      if (OUT_COL != LAST_COL) begin
        load   = 1'b1;
        ld_col = OUT_COL + CW'(1);
      end else if (nxt_full) begin
        load    = 1'b1;
        ld_data = nxt_data;
        ld_row  = nxt_row;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cap_row   <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_ROW   <= '0;
      OUT_COL   <= '0;
      OUT_FIRST <= 1'b0;
      OUT_LAST  <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (NEW_ROW && !wr_accept) OVERFLOW <= 1'b1;

      if (FRAME_FINISHED)  cap_row <= '0;
      else if (NEW_ROW)    cap_row <= (cap_row == LAST_ROW) ? '0 : cap_row + RW'(1);

      if (load) begin
        state     <= S_STREAM;
        OUT_VALID <= 1'b1;
        OUT_DATA  <= ld_data[int'(ld_col)*BITS +: BITS];
        OUT_ROW   <= ld_row;
        OUT_COL   <= ld_col;
        OUT_FIRST <= (ld_row == '0) && (ld_col == '0);
        OUT_LAST  <= (ld_row == LAST_ROW) && (ld_col == LAST_COL);
      end else if (xfer) begin
        state     <= S_IDLE;
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout: directed vector table, corner sequences, and random traffic against a queue model.
module tb_pixel_row_readout;
  import PixelSensorConfig::*;

  localparam int W  = PIXEL_ARRAY_WIDTH;
  localparam int H  = PIXEL_ARRAY_HEIGHT;
  localparam int B  = PIXEL_BITS;
  localparam int RW = ROW_IDX_BITS;
  localparam int CW = COL_IDX_BITS;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           new_row = 1'b0;
  logic [W*B-1:0] pixel_data = '0;
  logic           frame_finished = 1'b0;
  logic           out_ready = 1'b0;
  logic [B-1:0]   out_data;
  logic           out_valid;
  logic [RW-1:0]  out_row;
  logic [CW-1:0]  out_col;
  logic           out_first, out_last, overflow, busy;

  pixel_row_readout #(.WIDTH(W), .HEIGHT(H), .BITS(B)) dut (
    .CLK(clk), .RESET(reset), .NEW_ROW(new_row), .PIXEL_DATA(pixel_data),
    .FRAME_FINISHED(frame_finished), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_ROW(out_row), .OUT_COL(out_col),
    .OUT_FIRST(out_first), .OUT_LAST(out_last), .OVERFLOW(overflow), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of buffered rows (head is the one being streamed).
  typedef struct { logic [W*B-1:0] data; int row; } mrow_t;
  mrow_t m_rows[$];
  bit    m_valid = 1'b0;
  int    m_col = 0;
  bit    m_ovf = 1'b0;
  int    m_idx = 0;

  typedef struct { logic [B-1:0] d; int r; int c; bit f; bit l; } beat_t;
  beat_t got[$];

  typedef struct {
    bit rs; bit nr; bit ff; bit rdy; logic [W*B-1:0] pix;
    bit v; logic [B-1:0] d; int r; int c; bit f; bit l; bit ov; bit bz;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(bit rs, bit nr, bit ff, bit rdy, logic [W*B-1:0] pix,
                              bit v, logic [B-1:0] d, int r, int c, bit f, bit l, bit ov, bit bz);
    vec_t t;
    t.rs = rs; t.nr = nr; t.ff = ff; t.rdy = rdy; t.pix = pix;
    t.v = v; t.d = d; t.r = r; t.c = c; t.f = f; t.l = l; t.ov = ov; t.bz = bz;
    return t;
  endfunction

  function automatic void chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, fld, act, exp);
    end
  endfunction

  function automatic void model_step(bit nr, logic [W*B-1:0] pix, bit ff, bit rdy, bit rs);
    int n0;
    mrow_t nrow;
    if (rs) begin
      m_rows.delete();
      m_valid = 1'b0; m_col = 0; m_ovf = 1'b0; m_idx = 0;
      return;
    end
    n0 = m_rows.size();
    if (m_valid && rdy) begin
      if (m_col == W - 1) begin
        void'(m_rows.pop_front());
        m_col = 0;
        if (n0 < 2) m_valid = 1'b0;
      end else begin
        m_col++;
      end
    end else if (!m_valid && n0 > 0) begin
      m_valid = 1'b1;
      m_col = 0;
    end
    if (nr) begin
      if (m_rows.size() < 2) begin
        nrow.data = pix; nrow.row = m_idx;
        m_rows.push_back(nrow);
      end else begin
        m_ovf = 1'b1;
      end
      m_idx = (m_idx + 1) % H;
    end
    if (ff) m_idx = 0;
  endfunction

  task automatic cycle(input bit nr, input logic [W*B-1:0] pix, input bit ff, input bit rdy, input bit rs);
    beat_t bt;
    @(negedge clk);
    if (out_valid && rdy && !rs) begin
      bt.d = out_data; bt.r = int'(out_row); bt.c = int'(out_col); bt.f = out_first; bt.l = out_last;
      got.push_back(bt);
    end
    reset = rs; new_row = nr; pixel_data = pix; frame_finished = ff; out_ready = rdy;
    model_step(nr, pix, ff, rdy, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_model(input string tag);
    logic [W*B-1:0] rb;
    logic [B-1:0]   ep;
    int             er;
    chk(tag, "valid", 32'(out_valid), 32'(m_valid));
    chk(tag, "busy", 32'(busy), 32'((m_rows.size() > 0) || m_valid));
    chk(tag, "overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid) begin
      rb = m_rows[0].data;
      ep = rb[m_col*B +: B];
      er = m_rows[0].row;
      chk(tag, "data", 32'(out_data), 32'(ep));
      chk(tag, "row", 32'(out_row), 32'(er));
      chk(tag, "col", 32'(out_col), 32'(m_col));
      chk(tag, "first", 32'(out_first), 32'(er == 0 && m_col == 0));
      chk(tag, "last", 32'(out_last), 32'(er == H - 1 && m_col == W - 1));
    end
  endtask

  initial begin
    logic [31:0] rnd;
    bit          r_nr, r_ff, r_rdy, r_rs;

    tbl[0]  = mk(1, 1, 0, 0, 16'h1234, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 16'h5678, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 1, 16'h9ABC, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 1, 16'hBBAA, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 1, 16'h0000, 1, 8'hAA, 0, 0, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 1, 16'h0000, 1, 8'hBB, 0, 1, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 1, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 1, 16'hBBAA, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 1, 0, 1, 16'hDDCC, 1, 8'hAA, 0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 1, 16'h0000, 1, 8'hBB, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 1, 16'h0000, 1, 8'hCC, 1, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 16'h0000, 1, 8'hDD, 1, 1, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 0, 1, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, 0);

    // Directed table: reset, single row, back-to-back rows.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].nr, tbl[i].pix, tbl[i].ff, tbl[i].rdy, tbl[i].rs);
      chk($sformatf("tbl%0d", i), "valid", 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d", i), "busy", 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("tbl%0d", i), "overflow", 32'(overflow), 32'(tbl[i].ov));
      if (tbl[i].v || tbl[i].rs) begin
        chk($sformatf("tbl%0d", i), "data", 32'(out_data), 32'(tbl[i].d));
        chk($sformatf("tbl%0d", i), "row", 32'(out_row), 32'(tbl[i].r));
        chk($sformatf("tbl%0d", i), "col", 32'(out_col), 32'(tbl[i].c));
        chk($sformatf("tbl%0d", i), "first", 32'(out_first), 32'(tbl[i].f));
        chk($sformatf("tbl%0d", i), "last", 32'(out_last), 32'(tbl[i].l));
      end
    end

    // Stalled sink: beat held for five cycles, then each pixel moves once.
    got.delete();
    cycle(1, 16'hBBAA, 0, 0, 0);
    expect_model("stall");
    for (int k = 0; k < 5; k++) begin
      cycle(0, '0, 0, 0, 0);
      expect_model("stall");
      chk("stall_hold", "valid", 32'(out_valid), 32'd1);
      chk("stall_hold", "data", 32'(out_data), 32'hAA);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, '0, 0, 1, 0);
      expect_model("stall_drain");
    end
    chk("stall_drain", "beats", 32'(got.size()), 32'd2);
    chk("stall_drain", "beat0", 32'(got[0].d), 32'hAA);
    chk("stall_drain", "beat1", 32'(got[1].d), 32'hBB);

    // Overflow: third row with both buffers full is dropped.
    cycle(0, '0, 0, 0, 1);
    got.delete();
    cycle(1, 16'hBBAA, 0, 0, 0);
    cycle(1, 16'hDDCC, 0, 0, 0);
    cycle(1, 16'hFFEE, 0, 0, 0);
    expect_model("ovf");
    chk("ovf", "set", 32'(overflow), 32'd1);
    for (int k = 0; k < 8; k++) begin
      cycle(0, '0, 0, (k >= 2), 0);
      expect_model("ovf_drain");
    end
    chk("ovf_drain", "beats", 32'(got.size()), 32'd4);
    chk("ovf_drain", "beat0", 32'(got[0].d), 32'hAA);
    chk("ovf_drain", "beat1", 32'(got[1].d), 32'hBB);
    chk("ovf_drain", "beat2", 32'(got[2].d), 32'hCC);
    chk("ovf_drain", "beat3", 32'(got[3].d), 32'hDD);
    chk("ovf_drain", "sticky", 32'(overflow), 32'd1);

    // Frame end coincident with a row at index 1, then a fresh frame.
    cycle(0, '0, 0, 0, 1);
    got.delete();
    cycle(1, 16'hBBAA, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin cycle(0, '0, 0, 1, 0); expect_model("frame"); end
    cycle(1, 16'hDDCC, 1, 1, 0);
    expect_model("frame");
    cycle(1, 16'hFFEE, 0, 1, 0);
    expect_model("frame");
    for (int k = 0; k < 5; k++) begin cycle(0, '0, 0, 1, 0); expect_model("frame"); end
    chk("frame", "beats", 32'(got.size()), 32'd6);
    chk("frame", "dd_data", 32'(got[3].d), 32'hDD);
    chk("frame", "dd_row", 32'(got[3].r), 32'd1);
    chk("frame", "dd_last", 32'(got[3].l), 32'd1);
    chk("frame", "ee_data", 32'(got[4].d), 32'hEE);
    chk("frame", "ee_row", 32'(got[4].r), 32'd0);
    chk("frame", "ee_first", 32'(got[4].f), 32'd1);

    // Reset mid-stream discards the pending row.
    got.delete();
    cycle(1, 16'h2211, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    expect_model("midrst");
    cycle(0, '0, 0, 0, 1);
    chk("midrst", "valid", 32'(out_valid), 32'd0);
    chk("midrst", "busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, '0, 0, 1, 0);
      expect_model("midrst_after");
      chk("midrst_after", "valid", 32'(out_valid), 32'd0);
    end
    chk("midrst_after", "beats", 32'(got.size()), 32'd0);

    // Random traffic against the model.
    cycle(0, '0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      rnd   = $urandom;
      r_nr  = ($urandom_range(0, 2) == 0);
      r_ff  = ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rs  = ($urandom_range(0, 299) == 0);
      cycle(r_nr, rnd[W*B-1:0], r_ff, r_rdy, r_rs);
      expect_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
